// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; {rem,quo} result to HI/LO.
// Ports: clk, rst, start, signed_div, opdata1, opdata2, annul -> result_o, ready_o, stall_o. Option: DIV_ZERO_FASTPATH_EN.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_END
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [31:0] dvd_raw;
  logic        neg_q;
  logic        neg_r;
  logic        dz;

  logic        accept;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] sh_rem;
  logic [32:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign accept = (state == S_IDLE) & start & ~annul;
  assign a_mag  = (signed_div & opdata1[31]) ? -opdata1 : opdata1;
  assign b_mag  = (signed_div & opdata2[31]) ? -opdata2 : opdata2;

  // One restoring step: shift in next dividend bit, keep
  // the difference only when the trial subtract did not borrow.
  assign sh_rem  = {rem, quo[31]};
  assign diff    = sh_rem - {1'b0, dvs};
  assign rem_nxt = diff[32] ? sh_rem[31:0] : diff[31:0];
  assign quo_nxt = {quo[30:0], ~diff[32]};
  assign q_fix   = neg_q ? -quo_nxt : quo_nxt;
  assign r_fix   = neg_r ? -rem_nxt : rem_nxt;

  assign stall_o = accept | (state == S_BUSY);
  assign ready_o = (state == S_END) & ~annul;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvs      <= 32'd0;
      dvd_raw  <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      result_o <= 64'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            cnt     <= 5'd0;
            rem     <= 32'd0;
            quo     <= a_mag;
            dvs     <= b_mag;
            dvd_raw <= opdata1;
            neg_q   <= signed_div & (opdata1[31] ^ opdata2[31]);
            neg_r   <= signed_div & opdata1[31];
            dz      <= (opdata2 == 32'd0);
`ifdef DIV_ZERO_FASTPATH_EN
            if (opdata2 == 32'd0) begin
              state    <= S_END;
              result_o <= {opdata1, 32'hFFFF_FFFF};
            end else begin
              state <= S_BUSY;
            end
`else
            state <= S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          if (annul) begin
            state <= S_IDLE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state <= S_END;
              if (dz)
                result_o <= {dvd_raw, 32'hFFFF_FFFF};
              else
                result_o <= {r_fix, q_fix};
            end
          end
        end
        S_END: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit.
// Directed test-plan cases plus random back-to-back divisions.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [63:0] last_exp = 64'd0;

`ifdef DIV_ZERO_FASTPATH_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  div_unit dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_div(signed_div),
    .opdata1(opdata1),
    .opdata2(opdata2),
    .annul(annul),
    .result_o(result_o),
    .ready_o(ready_o),
    .stall_o(stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(
    input bit s,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {32'd0, 32'h8000_0000};
    sq = $signed(a) / $signed(b);
    sr = $signed(a) % $signed(b);
    return {sr, sq};
  endfunction

  task automatic run_div(
    input bit          s,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] exp,
    input int          lat,
    input string       nm
  );
    int n;
    int st;
    bit got;
    logic [63:0] e;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    signed_div = s;
    opdata1 = a;
    opdata2 = b;
    start = 1'b1;
    #1;
    st = stall_o ? 1 : 0;
    n = 0;
    got = 0;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      if (n == 1) begin
        #1;
        opdata1 = $urandom;
        opdata2 = $urandom;
        signed_div = ~s;
      end
      @(negedge clk);
      if (ready_o) got = 1;
      else if (stall_o) st++;
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no ready_o after %0d cycles, required %0d", nm, n, lat);
    end else if (result_o !== e) begin
      errors++;
      $display("FAIL %s result: got %h required %h", nm, result_o, e);
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", nm, n, lat);
    end
    checks++;
    if (st != lat) begin
      errors++;
      $display("FAIL %s stall cycles: got %0d required %0d", nm, st, lat);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s ready pulse width: ready_o %b required 0", nm, ready_o);
    end
    last_exp = e;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    signed_div = 1'b0;
    opdata1 = 32'd0;
    opdata2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (result_o !== 64'd0) begin
      errors++;
      $display("FAIL reset result_o: got %h required 0", result_o);
    end
    checks++;
    if (ready_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset ready/stall: got %b/%b required 0/0", ready_o, stall_o);
    end
  endtask

  task automatic test_divu();
    run_div(1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, "divu_100_7");
  endtask

  task automatic test_signed();
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 33, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE,
            64'h0000_0001_FFFF_FFFD, 33, "div_7_m2");
  endtask

  task automatic test_overflow();
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            64'h0000_0000_8000_0000, 33, "div_ovf");
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
            64'h8000_0000_0000_0000, 33, "divu_ovf");
  endtask

  task automatic test_divzero();
    run_div(1'b0, 32'h1234_5678, 32'd0,
            64'h1234_5678_FFFF_FFFF, ZLAT, "divu_zero");
    run_div(1'b1, 32'h8765_4321, 32'd0,
            64'h8765_4321_FFFF_FFFF, ZLAT, "div_zero");
  endtask

  task automatic test_annul();
    bit seen;
    @(posedge clk);
    #1;
    signed_div = 1'b0;
    opdata1 = 32'hDEAD_BEEF;
    opdata2 = 32'd3;
    start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    annul = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL annul idle: stall/ready %b/%b required 0/0", stall_o, ready_o);
    end
    checks++;
    if (result_o !== last_exp) begin
      errors++;
      $display("FAIL annul result kept: got %h required %h", result_o, last_exp);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL annul no ready: ready_o seen 1 required 0");
    end
    run_div(1'b0, 32'd9, 32'd3, 64'h0000_0000_0000_0003, 33, "divu_9_3");
  endtask

  task automatic test_rst_mid();
    @(posedge clk);
    #1;
    signed_div = 1'b1;
    opdata1 = 32'h7777_7777;
    opdata2 = 32'd5;
    start = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (result_o !== 64'd0 || ready_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: result/ready/stall %h/%b/%b required 0/0/0",
               result_o, ready_o, stall_o);
    end
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1,
            64'h0000_0000_FFFF_FFFF, 33, "divu_max_1");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    bit s;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
      if (b == 32'd0) b = 32'd1;
      s = i[1];
      run_div(s, a, b, model(s, a, b), 33, "random");
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_overflow();
    test_divzero();
    test_annul();
    test_rst_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
